// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI slave with all four clock modes. sck, ssn and mosi arrive asynchronously.
//   Each one passes through its own SYNC_STAGES-flop synchronizer. An edge
//   detector on the synchronized sck then drives an IDLE/ACTIVE state machine
//   that shifts out data_s on miso and shifts mosi into data_r_s, MSB first.
//   Bytes follow each other back to back while ssn stays low.
//
// Parameters
//   SYNC_STAGES : number of synchronizer flops on each async input (2..3)
//
// Ports
//   clk      in   system clock, every flop uses its rising edge
//   rst      in   synchronous active-high reset
//   data_s   in   [7:0] byte to transmit, captured on each tx_load
//   spcon    in   [7:0] control: bit6 spen, bit3 CPOL, bit2 CPHA
//   sck      in   SPI clock from the master (async)
//   ssn      in   active-low slave select (async)
//   mosi     in   master-out serial data (async)
//   miso     out  slave-out serial data, 0 when not selected
//   miso_oe  out  pad output enable for miso, high only while ACTIVE
//   data_r_s out  [7:0] last complete received byte
//   rx_done  out  one-cycle pulse when data_r_s updates
//   tx_load  out  one-cycle pulse when data_s is captured into the TX shifter
//   busy     out  high while in ACTIVE
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_s,
  input  logic [7:0] spcon,
  input  logic       sck,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] data_r_s,
  output logic       rx_done,
  output logic       tx_load,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // Synchronizers: new samples enter at bit 0, and the synchronized value is the MSB.
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ssn_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_ssn_d;

  state_t     r_state;
  logic       r_cpol;
  logic       r_cpha;
  logic [7:0] r_tx_sr;
  logic [7:0] r_rx_sr;
  logic [2:0] r_bit_cnt;
  logic       r_first;        // CPHA=1: the next leading edge is the first of a byte
  logic       r_reload_pend;  // CPHA=0: the next shift edge reloads data_s
  logic [7:0] r_data_r;
  logic       r_rx_done;
  logic       r_tx_load;

  logic w_sck_s;
  logic w_ssn_s;
  logic w_mosi_s;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_ssn_fall;
  logic w_lead;
  logic w_trail;
  logic w_sample;
  logic w_shift;
  logic w_spen;
  logic w_unused_spcon;

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_ssn_s  = r_ssn_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_ssn_fall = r_ssn_d & ~w_ssn_s;

  // The mode is the one latched at selection, so a change to spcon mid-selection
  // cannot move the edges.
  assign w_lead   = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail  = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? w_lead  : w_trail;

  assign w_spen         = spcon[6];
  assign w_unused_spcon = &{spcon[7], spcon[5:4], spcon[1:0]};

  // Synchronizers and edge-detect flops all reset to 0. If ssn is already low
  // when reset is released, no falling edge is seen. A transfer therefore needs
  // ssn to go high and then low again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_ssn_sync  <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ssn_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the value it had
      // before this edge, so the chain really is SYNC_STAGES flops deep.
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], ssn};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_d     <= w_sck_s;
      r_ssn_d     <= w_ssn_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_tx_sr       <= 8'h00;
      r_rx_sr       <= 8'h00;
      r_bit_cnt     <= 3'd0;
      r_first       <= 1'b0;
      r_reload_pend <= 1'b0;
      r_data_r      <= 8'h00;
      r_rx_done     <= 1'b0;
      r_tx_load     <= 1'b0;
    end else begin
      // Both pulses default low, which keeps each one to a single cycle.
      r_rx_done <= 1'b0;
      r_tx_load <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_ssn_fall && w_spen) begin
            r_state       <= S_ACTIVE;
            r_cpol        <= spcon[3];
            r_cpha        <= spcon[2];
            r_tx_sr       <= data_s;
            r_tx_load     <= 1'b1;
            r_bit_cnt     <= 3'd0;
            r_rx_sr       <= 8'h00;
            r_first       <= 1'b1;
            r_reload_pend <= 1'b0;
          end
        end

        S_ACTIVE: begin
          if (w_ssn_s || !w_spen) begin
            // Deselection or disable aborts any partial byte.
            r_state       <= S_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_sr       <= 8'h00;
            r_reload_pend <= 1'b0;
          end else begin
            // Sample and shift edges have opposite sck polarity, so at most
            // one of the two branches below runs in any cycle.
            if (w_sample) begin
              r_rx_sr   <= {r_rx_sr[6:0], w_mosi_s};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_data_r  <= {r_rx_sr[6:0], w_mosi_s};
                r_rx_done <= 1'b1;
                if (r_cpha) begin
                  // CPHA=1: the next byte's MSB has to be on miso before the
                  // next leading edge, so the reload happens now.
                  r_tx_sr   <= data_s;
                  r_tx_load <= 1'b1;
                  r_first   <= 1'b1;
                end else begin
                  r_reload_pend <= 1'b1;
                end
              end
            end

            if (w_shift) begin
              if (r_cpha) begin
                if (r_first) r_first <= 1'b0;
                else         r_tx_sr <= {r_tx_sr[6:0], 1'b0};
              end else if (r_reload_pend) begin
                r_tx_sr       <= data_s;
                r_tx_load     <= 1'b1;
                r_reload_pend <= 1'b0;
              end else begin
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy & r_tx_sr[7];
  assign data_r_s = r_data_r;
  assign rx_done  = r_rx_done;
  assign tx_load  = r_tx_load;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//   Directed testbench for spi_slave. It runs a bit-banged SPI master in modes
//   0 and 3, then covers a back-to-back byte pair, an aborted byte, a disabled
//   block and a reset in the middle of a byte. The expected values are worked
//   out by hand from the SPI protocol.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int HALF = 8;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_s;
  logic [7:0] spcon;
  logic       sck;
  logic       ssn;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] data_r_s;
  logic       rx_done;
  logic       tx_load;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int busy_cnt = 0;
  int oe_cnt = 0;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_s   (data_s),
    .spcon    (spcon),
    .sck      (sck),
    .ssn      (ssn),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .data_r_s (data_r_s),
    .rx_done  (rx_done),
    .tx_load  (tx_load),
    .busy     (busy)
  );

  // Pulse and level counters, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rx_done) rx_cnt++;
    if (tx_load) tx_cnt++;
    if (busy)    busy_cnt++;
    if (miso_oe) oe_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master for nbits bits. rxb collects miso, sampled at each master sample edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic cpol,
                          input logic cpha, output logic [7:0] rxb);
    rxb = 8'h00;
    if (!cpha) begin
      mosi = tx[7];
      for (int i = 0; i < nbits; i++) begin
        wait_clk(HALF);
        rxb = {rxb[6:0], miso};
        sck = ~cpol;
        wait_clk(HALF);
        sck = cpol;
        if (i < 7) mosi = tx[6-i];
      end
    end else begin
      for (int i = 0; i < nbits; i++) begin
        sck  = ~cpol;
        mosi = tx[7-i];
        wait_clk(HALF);
        rxb = {rxb[6:0], miso};
        sck = cpol;
        wait_clk(HALF);
      end
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] rb2;
    int rx0, tx0, busy0, oe0;

    // ---------------- reset ----------------
    rst = 1'b1; data_s = 8'h00; spcon = 8'h00; sck = 1'b0; ssn = 1'b1; mosi = 1'b0;
    wait_clk(3);
    check("rst_miso",    {7'd0, miso},    8'h00);
    check("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
    check("rst_data_r",  data_r_s,        8'h00);
    check("rst_rx_done", {7'd0, rx_done}, 8'h00);
    check("rst_tx_load", {7'd0, tx_load}, 8'h00);
    check("rst_busy",    {7'd0, busy},    8'h00);
    rst = 1'b0;
    wait_clk(5);

    // ---------------- mode 0: tx A5, rx 3C ----------------
    spcon = 8'h40; data_s = 8'hA5;
    rx0 = rx_cnt; tx0 = tx_cnt;
    ssn = 1'b0;
    wait_clk(6);
    check("m0_busy",      {7'd0, busy},    8'h01);
    check("m0_miso_oe",   {7'd0, miso_oe}, 8'h01);
    check("m0_first_bit", {7'd0, miso},    8'h01);
    check("m0_tx_load1",  8'(tx_cnt - tx0), 8'd1);
    spi_bits(8'h3C, 8, 1'b0, 1'b0, rb);
    wait_clk(HALF);
    ssn = 1'b1;
    wait_clk(6);
    check("m0_data_r",    data_r_s,         8'h3C);
    check("m0_rx_done",   8'(rx_cnt - rx0), 8'd1);
    check("m0_tx_load",   8'(tx_cnt - tx0), 8'd2);
    check("m0_miso_byte", rb,               8'hA5);
    check("m0_idle_busy", {7'd0, busy},     8'h00);
    check("m0_idle_oe",   {7'd0, miso_oe},  8'h00);
    check("m0_idle_miso", {7'd0, miso},     8'h00);

    // ---------------- abort after 5 bits ----------------
    rx0 = rx_cnt;
    ssn = 1'b0;
    wait_clk(6);
    spi_bits(8'hF0, 5, 1'b0, 1'b0, rb);
    wait_clk(2);
    ssn = 1'b1;
    wait_clk(6);
    check("ab_rx_done", 8'(rx_cnt - rx0), 8'd0);
    check("ab_data_r",  data_r_s,         8'h3C);
    check("ab_miso_oe", {7'd0, miso_oe},  8'h00);
    check("ab_busy",    {7'd0, busy},     8'h00);

    // ---------------- mode 3: tx 5A, rx C3 ----------------
    spcon = 8'h4C; sck = 1'b1;
    wait_clk(8);
    data_s = 8'h5A;
    rx0 = rx_cnt; tx0 = tx_cnt;
    ssn = 1'b0;
    wait_clk(HALF);
    spi_bits(8'hC3, 8, 1'b1, 1'b1, rb);
    ssn = 1'b1;
    wait_clk(6);
    check("m3_data_r",    data_r_s,         8'hC3);
    check("m3_miso_byte", rb,               8'h5A);
    check("m3_rx_done",   8'(rx_cnt - rx0), 8'd1);
    check("m3_tx_load",   8'(tx_cnt - tx0), 8'd2);

    // ---------------- mode 0: two bytes back to back ----------------
    spcon = 8'h40; sck = 1'b0;
    wait_clk(8);
    data_s = 8'h99;
    rx0 = rx_cnt; tx0 = tx_cnt;
    ssn = 1'b0;
    wait_clk(6);
    check("bb_tx_load1", 8'(tx_cnt - tx0), 8'd1);
    data_s = 8'h77;
    spi_bits(8'h12, 8, 1'b0, 1'b0, rb);
    check("bb_data_r1", data_r_s, 8'h12);
    check("bb_miso1",   rb,       8'h99);
    spi_bits(8'h34, 8, 1'b0, 1'b0, rb2);
    wait_clk(HALF);
    ssn = 1'b1;
    wait_clk(6);
    check("bb_data_r2",  data_r_s,         8'h34);
    check("bb_miso2",    rb2,              8'h77);
    check("bb_rx_done",  8'(rx_cnt - rx0), 8'd2);
    check("bb_tx_load",  8'(tx_cnt - tx0), 8'd3);

    // ---------------- disabled block ----------------
    spcon = 8'h00;
    wait_clk(4);
    rx0 = rx_cnt; tx0 = tx_cnt; busy0 = busy_cnt; oe0 = oe_cnt;
    ssn = 1'b0;
    wait_clk(HALF);
    spi_bits(8'hAA, 8, 1'b0, 1'b0, rb);
    wait_clk(HALF);
    ssn = 1'b1;
    wait_clk(6);
    check("dis_busy",    8'(busy_cnt - busy0), 8'd0);
    check("dis_miso_oe", 8'(oe_cnt - oe0),     8'd0);
    check("dis_rx_done", 8'(rx_cnt - rx0),     8'd0);
    check("dis_tx_load", 8'(tx_cnt - tx0),     8'd0);

    // ---------------- reset in the middle of a byte ----------------
    spcon = 8'h40; data_s = 8'hC6;
    ssn = 1'b0;
    wait_clk(6);
    spi_bits(8'hFF, 3, 1'b0, 1'b0, rb);
    rst = 1'b1;
    wait_clk(2);
    check("mr_data_r",  data_r_s,         8'h00);
    check("mr_busy",    {7'd0, busy},     8'h00);
    check("mr_miso_oe", {7'd0, miso_oe},  8'h00);
    check("mr_miso",    {7'd0, miso},     8'h00);
    check("mr_rx_done", {7'd0, rx_done},  8'h00);
    check("mr_tx_load", {7'd0, tx_load},  8'h00);
    rst = 1'b0;
    wait_clk(4);
    rx0 = rx_cnt;
    spi_bits(8'h81, 8, 1'b0, 1'b0, rb);
    wait_clk(HALF);
    check("mr_held_rx_done", 8'(rx_cnt - rx0), 8'd0);
    check("mr_held_busy",    {7'd0, busy},     8'h00);
    ssn = 1'b1;
    wait_clk(6);
    ssn = 1'b0;
    wait_clk(6);
    check("mr_resel_busy", {7'd0, busy}, 8'h01);
    spi_bits(8'h5E, 8, 1'b0, 1'b0, rb);
    wait_clk(HALF);
    ssn = 1'b1;
    wait_clk(6);
    check("mr_resel_data_r",  data_r_s,         8'h5E);
    check("mr_resel_rx_done", 8'(rx_cnt - rx0), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops on sck, ssn and mosi (legal 2..3).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port data_s, input, 8, the byte to transmit, captured at each tx_load.
REQ-005 The block SHALL have port spcon, input, 8, control: bit6 spen, bit3 CPOL, bit2 CPHA, other bits ignored.
REQ-006 The block SHALL have port sck, input, 1, the asynchronous SPI clock from the master.
REQ-007 The block SHALL have port ssn, input, 1, the asynchronous active-low slave select.
REQ-008 The block SHALL have port mosi, input, 1, asynchronous master-out serial data.
REQ-009 The block SHALL have port miso, output, 1, slave-out serial data.
REQ-010 The block SHALL have port miso_oe, output, 1, miso output enable for the pad tri-state.
REQ-011 The block SHALL have port data_r_s, output, 8, the last complete received byte.
REQ-012 The block SHALL have port rx_done, output, 1, a one-cycle pulse when data_r_s updates.
REQ-013 The block SHALL have port tx_load, output, 1, a one-cycle pulse when data_s is captured into the TX shifter.
REQ-014 The block SHALL have port busy, output, 1, high while in state ACTIVE.

Function
REQ-015 The block SHALL synchronize sck, ssn and mosi through SYNC_STAGES flops and detect sck edges by comparing the synchronized value with a one-cycle-delayed copy.
REQ-016 The block SHALL implement FSM states IDLE and ACTIVE: IDLE->ACTIVE on a synchronized ssn 1->0 transition while spen=1; ACTIVE->IDLE when synchronized ssn=1 or spen=0.
REQ-017 On IDLE->ACTIVE the block SHALL latch CPOL/CPHA for the whole selection, load tx_sr<=data_s, pulse tx_load, clear bit_cnt (3 bits) and rx_sr; spcon mode changes during ACTIVE SHALL be ignored.
REQ-018 The leading edge SHALL be rising for CPOL=0 and falling for CPOL=1; the sample edge SHALL be leading for CPHA=0 and trailing for CPHA=1; the other edge is the shift edge.
REQ-019 miso SHALL equal tx_sr[7] and miso_oe SHALL be 1 only in ACTIVE; in IDLE miso=0 and miso_oe=0.
REQ-020 On each sample edge the block SHALL set rx_sr<={rx_sr[6:0],mosi_sync} and increment bit_cnt modulo 8.
REQ-021 On the 8th sample edge (bit_cnt=7) data_r_s SHALL take {rx_sr[6:0],mosi_sync} and rx_done SHALL be high for exactly the following cycle.
REQ-022 For CPHA=0, every shift edge SHALL shift tx_sr left, except the shift edge after the 8th sample, which SHALL reload tx_sr<=data_s and pulse tx_load.
REQ-023 For CPHA=1, the first leading edge of each byte SHALL NOT shift and later leading edges SHALL shift tx_sr left; the 8th sample edge SHALL reload tx_sr<=data_s and pulse tx_load.
REQ-024 Bytes SHALL continue back-to-back while ssn stays low, with no gap cycles required.
REQ-025 ssn high or spen=0 before the 8th sample edge SHALL abort the byte: no rx_done, data_r_s unchanged, bit_cnt cleared, return to IDLE.
REQ-026 rx_done/data_r_s SHALL update on the clk edge SYNC_STAGES edges after the edge that first captures the raw sck sample transition.
REQ-027 Correct operation SHALL require each sck high and low phase to be at least SYNC_STAGES+2 clk periods.

Reset
REQ-028 While rst=1: FSM=IDLE; miso=0, miso_oe=0, data_r_s=0x00, rx_done=0, tx_load=0, busy=0; tx_sr, rx_sr, bit_cnt cleared.
REQ-029 While rst=1 the ssn and sck synchronizer chains and the edge-detect flops SHALL reset to 0, so a selection already low at reset release starts no transfer and the first sck edge after reset is not falsely detected.
REQ-030 rst asserted mid-byte SHALL discard the byte; a new transfer SHALL start only after ssn is seen high, then low.

Verification
REQ-031 Mode 0: data_s=0xA5, master sends 0x3C -> data_r_s=0x3C, one rx_done pulse, miso bits 1,0,1,0,0,1,0,1.
REQ-032 Mode 3 (CPOL=1, CPHA=1): data_s=0x5A, master sends 0xC3 -> data_r_s=0xC3, miso bits 0,1,0,1,1,0,1,0.
REQ-033 Mode 0: two bytes 0x12, 0x34 in one ssn-low window, with data_s changed to 0x77 after the first tx_load -> rx_done twice (0x12, then 0x34), tx_load 3 pulses, second miso byte 0x77.
REQ-034 ssn raised after 5 sck pulses, prior data_r_s=0x3C -> no rx_done, data_r_s=0x3C, miso_oe=0, busy=0.
REQ-035 spcon=0x00 with a full 8-bit burst -> busy, miso_oe, rx_done and tx_load stay 0.
REQ-036 rst pulsed after 3 bits with ssn held low -> outputs at reset values, no rx_done until ssn toggles high then low.
